// File: rtl/alu_decode_stage.sv
// MIPS ALU decode stage: instruction in, decoded control packet out.
// Two-entry elastic buffer (output + skid register) with saturating illegal count.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  alu_op,
    output logic [31:0] imm_ext,
    output logic        alusrc,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        memwrite,
    output logic        branch,
    output logic        illegal,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  wreg,
    output logic [7:0]  illegal_cnt
);
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_ANDI_OP = 8'b0101_1001;
    localparam logic [7:0] EXE_ORI_OP  = 8'b0101_1010;
    localparam logic [7:0] EXE_XORI_OP = 8'b0101_1011;
    localparam logic [7:0] EXE_LUI_OP  = 8'b0101_1100;
    localparam logic [7:0] EXE_ADDI_OP = 8'b0101_0101;
    localparam logic [7:0] EXE_BEQ_OP  = 8'b0101_0001;
    localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;

    typedef struct packed {
        logic [7:0]  alu_op;
        logic [31:0] imm_ext;
        logic        alusrc;
        logic        regwrite;
        logic        regdst;
        logic        memtoreg;
        logic        memwrite;
        logic        branch;
        logic        illegal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
    } pkt_t;

    pkt_t dec, out_q, skid_q;
    logic out_v, skid_v;
    logic acc, pop, bad;
    logic [5:0] opc, funct;
    logic [31:0] zimm, simm;
    logic unused_shamt;

    assign opc   = instr[31:26];
    assign funct = instr[5:0];
    assign zimm  = {16'h0000, instr[15:0]};
    assign simm  = {{16{instr[15]}}, instr[15:0]};
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        dec    = '0;
        bad    = 1'b0;
        unique case (1'b1)
            opc == 6'b000000: begin
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
                unique case (funct)
                    6'b100100: dec.alu_op = EXE_AND_OP;
                    6'b100101: dec.alu_op = EXE_OR_OP;
                    6'b100110: dec.alu_op = EXE_XOR_OP;
                    6'b100111: dec.alu_op = EXE_NOR_OP;
                    6'b100000: dec.alu_op = EXE_ADD_OP;
                    6'b100010: dec.alu_op = EXE_SUB_OP;
                    6'b101010: dec.alu_op = EXE_SLT_OP;
                    default:   bad = 1'b1;
                endcase
            end
            opc == 6'b001100,
            opc == 6'b001101,
            opc == 6'b001110,
            opc == 6'b001111: begin
                dec.imm_ext  = zimm;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                unique case (opc[1:0])
                    2'b00:   dec.alu_op = EXE_ANDI_OP;
                    2'b01:   dec.alu_op = EXE_ORI_OP;
                    2'b10:   dec.alu_op = EXE_XORI_OP;
                    default: dec.alu_op = EXE_LUI_OP;
                endcase
            end
            opc == 6'b001000: begin
                dec.alu_op   = EXE_ADDI_OP;
                dec.imm_ext  = simm;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            opc == 6'b100011: begin
                dec.alu_op   = EXE_LW_OP;
                dec.imm_ext  = simm;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
            end
            opc == 6'b101011: begin
                dec.alu_op   = EXE_SW_OP;
                dec.imm_ext  = simm;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            opc == 6'b000100: begin
                dec.alu_op  = EXE_BEQ_OP;
                dec.imm_ext = simm;
                dec.branch  = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // illegal packets carry register fields only, no controls
        if (bad) begin
            dec         = '0;
            dec.alu_op  = EXE_NOP_OP;
            dec.illegal = 1'b1;
        end
        dec.rs   = instr[25:21];
        dec.rt   = instr[20:16];
        dec.wreg = dec.regdst ? instr[15:11] : instr[20:16];
    end

    assign in_ready = ~skid_v | rst;
    assign acc      = in_valid & ~skid_v;
    assign pop      = out_v & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v       <= 1'b0;
            skid_v      <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
            illegal_cnt <= 8'h00;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (acc && dec.illegal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
            if (!out_v || pop) begin
                if (skid_v) begin
                    out_q  <= skid_q;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                    skid_q <= '0;
                end else if (acc) begin
                    out_q <= dec;
                    out_v <= 1'b1;
                end else begin
                    out_q <= '0;
                    out_v <= 1'b0;
                end
            end else if (acc) begin
                skid_q <= dec;
                skid_v <= 1'b1;
            end
        end
    end

    assign out_valid = out_v;
    assign alu_op    = out_q.alu_op;
    assign imm_ext   = out_q.imm_ext;
    assign alusrc    = out_q.alusrc;
    assign regwrite  = out_q.regwrite;
    assign regdst    = out_q.regdst;
    assign memtoreg  = out_q.memtoreg;
    assign memwrite  = out_q.memwrite;
    assign branch    = out_q.branch;
    assign illegal   = out_q.illegal;
    assign rs        = out_q.rs;
    assign rt        = out_q.rt;
    assign wreg      = out_q.wreg;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: driver pushes expected packets,
// negedge monitor pops and compares on every output transfer.
module tb_alu_decode_stage;
    localparam logic [7:0] ADD_OP  = 8'b0010_0000;
    localparam logic [7:0] AND_OP  = 8'b0010_0100;
    localparam logic [7:0] SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] ORI_OP  = 8'b0101_1010;
    localparam logic [7:0] XORI_OP = 8'b0101_1011;
    localparam logic [7:0] LUI_OP  = 8'b0101_1100;
    localparam logic [7:0] ADDI_OP = 8'b0101_0101;
    localparam logic [7:0] BEQ_OP  = 8'b0101_0001;
    localparam logic [7:0] LW_OP   = 8'b1110_0011;
    localparam logic [7:0] SW_OP   = 8'b1110_1011;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] imm;
        logic [6:0]  ctl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, imm_ext;
    logic [7:0] alu_op, illegal_cnt;
    logic alusrc, regwrite, regdst, memtoreg, memwrite, branch, illegal;
    logic [4:0] rs, rt, wreg;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [7:0] exp_cnt = 8'h00;
    exp_t act;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .imm_ext(imm_ext),
        .alusrc(alusrc), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch),
        .illegal(illegal), .rs(rs), .rt(rt), .wreg(wreg),
        .illegal_cnt(illegal_cnt)
    );

    assign act = {alu_op, imm_ext,
                  {alusrc, regwrite, regdst, memtoreg, memwrite, branch, illegal},
                  rs, rt, wreg};

    function automatic exp_t mk(input logic [7:0] op, input logic [31:0] imm,
                                input logic [6:0] ctl, input logic [4:0] s,
                                input logic [4:0] t, input logic [4:0] w);
        mk = {op, imm, ctl, s, t, w};
    endfunction

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic send(input logic [31:0] w, input exp_t e);
        int n = 0;
        instr    = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        if (e.ctl[0] && exp_cnt != 8'hFF)
            exp_cnt = exp_cnt + 8'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_cnt"}, 64'(illegal_cnt), 64'd0);
        chk({tag, "_pkt"}, 64'(act), 64'd0);
    endtask

    // monitor: compare on transfers, check stall stability and idle controls
    initial begin
        exp_t e, prev;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !rst && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pkt", 64'(act), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pkt", 64'(act), 64'(e));
                end
            end
            if (!out_valid)
                chk("idle_ctl", 64'({alu_op, act.ctl}), 64'd0);
            if (prev_stall && out_valid)
                chk("stall_stable", 64'(act), 64'(prev));
            prev_stall = out_valid && !out_ready && !rst && !flush;
            prev = act;
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        instr = 32'h0; out_ready = 1'b0;
        #1;
        chk("ready_in_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        out_ready = 1'b1;

        send(32'h00851020, mk(ADD_OP, 32'h0, 7'b0110000, 5'd4, 5'd5, 5'd2));
        chk("latency_valid", 64'(out_valid), 64'd1);
        send(32'h2002FFFF, mk(ADDI_OP, 32'hFFFFFFFF, 7'b1100000, 5'd0, 5'd2, 5'd2));
        send(32'h3402FFFF, mk(ORI_OP, 32'h0000FFFF, 7'b1100000, 5'd0, 5'd2, 5'd2));
        send(32'h8C830004, mk(LW_OP, 32'h4, 7'b1101000, 5'd4, 5'd3, 5'd3));
        send(32'hAC83FFF8, mk(SW_OP, 32'hFFFFFFF8, 7'b1000100, 5'd4, 5'd3, 5'd3));
        send(32'h10850003, mk(BEQ_OP, 32'h3, 7'b0000010, 5'd4, 5'd5, 5'd5));
        send(32'h3C011234, mk(LUI_OP, 32'h1234, 7'b1100000, 5'd0, 5'd1, 5'd1));
        send(32'h00A41824, mk(AND_OP, 32'h0, 7'b0110000, 5'd5, 5'd4, 5'd3));
        send(32'h00A41808, mk(8'h00, 32'h0, 7'b0000001, 5'd5, 5'd4, 5'd4));
        send(32'h00A4182A, mk(SLT_OP, 32'h0, 7'b0110000, 5'd5, 5'd4, 5'd3));
        drain();
        chk("cnt_one", 64'(illegal_cnt), 64'(exp_cnt));

        out_ready = 1'b0;
        send(32'h3882F0F0, mk(XORI_OP, 32'h0000F0F0, 7'b1100000, 5'd4, 5'd2, 5'd2));
        send(32'h3C011234, mk(LUI_OP, 32'h1234, 7'b1100000, 5'd0, 5'd1, 5'd1));
        chk("full_not_ready", 64'(in_ready), 64'd0);
        fork
            send(32'h00A41824, mk(AND_OP, 32'h0, 7'b0110000, 5'd5, 5'd4, 5'd3));
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("stall_not_ready", 64'(in_ready), 64'd0);
                chk("stall_head", 64'(alu_op), 64'(XORI_OP));
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(32'h3882F0F0, mk(XORI_OP, 32'h0000F0F0, 7'b1100000, 5'd4, 5'd2, 5'd2));
        send(32'h10850003, mk(BEQ_OP, 32'h3, 7'b0000010, 5'd4, 5'd5, 5'd5));
        chk("flush_full", 64'(in_ready), 64'd0);
        flush = 1'b1; in_valid = 1'b1; instr = 32'hFC000000;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        chk("flush_pkt", 64'(act), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        out_ready = 1'b1;
        repeat (300)
            send(32'hFC000000, mk(8'h00, 32'h0, 7'b0000001, 5'd0, 5'd0, 5'd0));
        drain();
        chk("sat_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        chk("sat_ff", 64'(illegal_cnt), 64'hFF);

        out_ready = 1'b0;
        send(32'h00851020, mk(ADD_OP, 32'h0, 7'b0110000, 5'd4, 5'd5, 5'd2));
        send(32'h2002FFFF, mk(ADDI_OP, 32'hFFFFFFFF, 7'b1100000, 5'd0, 5'd2, 5'd2));
        chk("rst_full", 64'(in_ready), 64'd0);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; instr = 32'h00851020;
        #1;
        chk("ready_in_rst2", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk_reset_vals("rst_flush");
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        exp_cnt = 8'h00;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        send(32'h00A4182A, mk(SLT_OP, 32'h0, 7'b0110000, 5'd5, 5'd4, 5'd3));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
